wb_arbiter: RTL and testbench

- Write-back arbiter that drives the register file's single write port (we/waddr/wdata).
- Merges two result streams:
  - the in-order pipeline write-back, which always has priority;
  - a long-latency unit (divider/multi-cycle load), which is handshaked and buffered in a small FIFO.
- Pending buffered results drain in order whenever the pipeline does not write.
- Back-pressures the pipeline via stallreq when the buffer is full.

---
 rtl/wb_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_wb_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//
// Purpose:
//   Drives the register file's single write port. Two result streams share it:
//     - the in-order pipeline write-back, which always wins;
//     - a long-latency unit (divider / multi-cycle load), handshaked with
//       lu_valid/lu_ready and buffered in a small in-order FIFO.
//   Buffered results drain in order on cycles where the pipeline does not
//   write. A pipeline write to register A supersedes every older long-unit
//   result to A: buffered entries become dead and are later popped silently.
//
// Ports:
//   clk                    clock, rising edge
//   rst                    asynchronous reset, active low
//   pipe_we/waddr/wdata    pipeline write-back request
//   lu_valid/ready         long-unit handshake
//   lu_waddr/wdata         long-unit result
//   we/waddr/wdata         registered register-file write port
//   pend_cnt               number of live (not superseded) buffered results
//   stallreq               buffer full, pipeline must stall
//
// Optional feature (macro WB_PEND_FWD_EN):
//   fwd_raddr/fwd_hit/fwd_data: combinational lookup of the youngest live
//   buffered result, or the outgoing registered write, for decode forwarding.
// ---------------------------------------------------------------------------
module wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pipe_we,
  input  logic [ADDR_W-1:0]          pipe_waddr,
  input  logic [DATA_W-1:0]          pipe_wdata,
  input  logic                       lu_valid,
  output logic                       lu_ready,
  input  logic [ADDR_W-1:0]          lu_waddr,
  input  logic [DATA_W-1:0]          lu_wdata,
  output logic                       we,
  output logic [ADDR_W-1:0]          waddr,
  output logic [DATA_W-1:0]          wdata,
  output logic [$clog2(DEPTH):0]     pend_cnt,
`ifdef WB_PEND_FWD_EN
  input  logic [ADDR_W-1:0]          fwd_raddr,
  output logic                       fwd_hit,
  output logic [DATA_W-1:0]          fwd_data,
`endif
  output logic                       stallreq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [DEPTH-1:0]  mem_live;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  // Occupancy including dead entries; this is what gates new pushes.
  logic [CNT_W-1:0]  count;

  logic              pipe_vld;
  logic              lu_acc;
  logic              lu_nz;
  logic              lu_kill;
  logic              fifo_empty;
  logic              issue_we;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] issue_data;
  logic              pop;
  logic              bypass;
  logic              push;
  logic [CNT_W-1:0]  live_cnt;

  assign pipe_vld   = pipe_we && (pipe_waddr != '0);
  assign lu_ready   = (count < DEPTH_C);
  assign stallreq   = (count == DEPTH_C);
  assign lu_acc     = lu_valid && lu_ready;
  assign lu_nz      = lu_acc && (lu_waddr != '0);
  // A same-cycle pipeline write to the same register is younger, so the
  // long-unit result is dropped instead of being buffered.
  assign lu_kill    = pipe_vld && (lu_waddr == pipe_waddr);
  assign fifo_empty = (count == '0);

  // Issue selection: pipeline first, then the FIFO head (live or dead),
  // then a direct bypass of a fresh long-unit result when the FIFO is empty.
  always_comb begin
    issue_we   = 1'b0;
    issue_addr = pipe_waddr;
    issue_data = pipe_wdata;
    pop        = 1'b0;
    bypass     = 1'b0;
    if (pipe_vld) begin
      issue_we = 1'b1;
    end else if (!fifo_empty) begin
      pop        = 1'b1;
      issue_we   = mem_live[rd_ptr];
      issue_addr = mem_addr[rd_ptr];
      issue_data = mem_data[rd_ptr];
    end else if (lu_nz) begin
      bypass     = 1'b1;
      issue_we   = 1'b1;
      issue_addr = lu_waddr;
      issue_data = lu_wdata;
    end
  end

  assign push = lu_nz && !lu_kill && !bypass;

  // Live-entry count. Live bits are only ever set on occupied slots.
  always_comb begin
    live_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      live_cnt = live_cnt + CNT_W'(mem_live[i]);
    end
  end

  assign pend_cnt = live_cnt;

  // Registered write port; address and data hold when nothing issues.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      we <= issue_we;
      if (issue_we) begin
        waddr <= issue_addr;
        wdata <= issue_data;
      end
    end
  end

  // FIFO storage. Supersede marking runs first; the pop clear and push set
  // cannot hit the same slot because a push needs a free slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_live <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr[i] <= '0;
        mem_data[i] <= '0;
      end
    end else begin
      if (pipe_vld) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (mem_addr[i] == pipe_waddr) begin
            mem_live[i] <= 1'b0;
          end
        end
      end
      if (pop) begin
        mem_live[rd_ptr] <= 1'b0;
      end
      if (push) begin
        mem_live[wr_ptr] <= 1'b1;
        mem_addr[wr_ptr] <= lu_waddr;
        mem_data[wr_ptr] <= lu_wdata;
      end
    end
  end

  // Pointers wrap naturally modulo DEPTH (power of two).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef WB_PEND_FWD_EN
  logic [PTR_W-1:0] fwd_idx;

  // Youngest match wins: the outgoing write is older than anything still
  // live in the FIFO, and the FIFO is scanned oldest to youngest.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = rd_ptr;
    if (fwd_raddr != '0) begin
      if (we && (waddr == fwd_raddr)) begin
        fwd_hit  = 1'b1;
        fwd_data = wdata;
      end
      for (int k = 0; k < DEPTH; k++) begin
        fwd_idx = rd_ptr + PTR_W'(k);
        if ((CNT_W'(k) < count) && mem_live[fwd_idx] &&
            (mem_addr[fwd_idx] == fwd_raddr)) begin
          fwd_hit  = 1'b1;
          fwd_data = mem_data[fwd_idx];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter
//
// Directed, table-driven bench for wb_arbiter (DATA_W=32, ADDR_W=5,
// DEPTH=4). Each vector holds the inputs for one cycle and the outputs
// expected just after the following rising edge. A hand-written sequence
// covers asynchronous reset while results are buffered.
// ---------------------------------------------------------------------------
module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [2:0]  pend_cnt;
  logic        stallreq;
`ifdef WB_PEND_FWD_EN
  logic [4:0]  fwd_raddr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif

  int checks = 0;
  int errors = 0;

  wb_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_we    (pipe_we),
    .pipe_waddr (pipe_waddr),
    .pipe_wdata (pipe_wdata),
    .lu_valid   (lu_valid),
    .lu_ready   (lu_ready),
    .lu_waddr   (lu_waddr),
    .lu_wdata   (lu_wdata),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .pend_cnt   (pend_cnt),
`ifdef WB_PEND_FWD_EN
    .fwd_raddr  (fwd_raddr),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data),
`endif
    .stallreq   (stallreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        p_we;
    logic [4:0]  p_addr;
    logic [31:0] p_data;
    logic        l_valid;
    logic [4:0]  l_addr;
    logic [31:0] l_data;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [2:0]  e_pend;
    logic        e_ready;
    logic        e_stall;
  } vec_t;

  vec_t vq[$];

  task automatic addVec(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld,
                        input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                        input logic [2:0] ep, input logic er, input logic es);
    vec_t v;
    v.p_we = pw; v.p_addr = pa; v.p_data = pd;
    v.l_valid = lv; v.l_addr = la; v.l_data = ld;
    v.e_we = ew; v.e_addr = ea; v.e_data = ed;
    v.e_pend = ep; v.e_ready = er; v.e_stall = es;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                               input logic lv, input logic [4:0] la, input logic [31:0] ld);
    @(negedge clk);
    pipe_we = pw; pipe_waddr = pa; pipe_wdata = pd;
    lu_valid = lv; lu_waddr = la; lu_wdata = ld;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic ew, input logic [4:0] ea,
                             input logic [31:0] ed, input logic [2:0] ep,
                             input logic er, input logic es);
    check({tag, ".we"},       32'(we),       32'(ew));
    check({tag, ".waddr"},    32'(waddr),    32'(ea));
    check({tag, ".wdata"},    wdata,         ed);
    check({tag, ".pend_cnt"}, 32'(pend_cnt), 32'(ep));
    check({tag, ".lu_ready"}, 32'(lu_ready), 32'(er));
    check({tag, ".stallreq"}, 32'(stallreq), 32'(es));
  endtask

  initial begin
    rst = 1'b0;
    pipe_we = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
    lu_valid = 1'b0; lu_waddr = '0; lu_wdata = '0;
`ifdef WB_PEND_FWD_EN
    fwd_raddr = '0;
`endif

    //      pw pa  pd          lv la  ld          ew ea  ed          ep er es
    // idle and single pipe write
    addVec(0, 0,  32'h0,      0, 0,  32'h0,      0, 0,  32'h0,      0, 1, 0);
    addVec(1, 3,  32'h11,     0, 0,  32'h0,      1, 3,  32'h11,     0, 1, 0);
    addVec(0, 0,  32'h0,      0, 0,  32'h0,      0, 3,  32'h11,     0, 1, 0);
    // bypass with empty FIFO
    addVec(0, 0,  32'h0,      1, 5,  32'hAA,     1, 5,  32'hAA,     0, 1, 0);
    addVec(0, 0,  32'h0,      0, 0,  32'h0,      0, 5,  32'hAA,     0, 1, 0);
    // fill FIFO behind continuous pipe writes
    addVec(1, 1,  32'h101,    1, 7,  32'h707,    1, 1,  32'h101,    1, 1, 0);
    addVec(1, 2,  32'h102,    1, 8,  32'h808,    1, 2,  32'h102,    2, 1, 0);
    addVec(1, 3,  32'h103,    1, 9,  32'h909,    1, 3,  32'h103,    3, 1, 0);
    addVec(1, 4,  32'h104,    1, 10, 32'hA0A,    1, 4,  32'h104,    4, 0, 1);
    addVec(1, 5,  32'h105,    1, 11, 32'hB0B,    1, 5,  32'h105,    4, 0, 1);
    addVec(1, 6,  32'h106,    0, 0,  32'h0,      1, 6,  32'h106,    4, 0, 1);
    // in-order drain
    addVec(0, 0,  32'h0,      0, 0,  32'h0,      1, 7,  32'h707,    3, 1, 0);
    addVec(0, 0,  32'h0,      0, 0,  32'h0,      1, 8,  32'h808,    2, 1, 0);
    addVec(0, 0,  32'h0,      0, 0,  32'h0,      1, 9,  32'h909,    1, 1, 0);
    addVec(0, 0,  32'h0,      0, 0,  32'h0,      1, 10, 32'hA0A,    0, 1, 0);
    addVec(0, 0,  32'h0,      0, 0,  32'h0,      0, 10, 32'hA0A,    0, 1, 0);
    // supersede of a buffered entry
    addVec(1, 4,  32'h44,     1, 9,  32'h1,      1, 4,  32'h44,     1, 1, 0);
    addVec(1, 9,  32'h2,      0, 0,  32'h0,      1, 9,  32'h2,      0, 1, 0);
    addVec(0, 0,  32'h0,      0, 0,  32'h0,      0, 9,  32'h2,      0, 1, 0);
    addVec(0, 0,  32'h0,      0, 0,  32'h0,      0, 9,  32'h2,      0, 1, 0);
    addVec(0, 0,  32'h0,      1, 13, 32'h1313,   1, 13, 32'h1313,   0, 1, 0);
    // long-unit writes to register 0 are dropped
    addVec(0, 0,  32'h0,      1, 0,  32'hDEAD,   0, 13, 32'h1313,   0, 1, 0);
    addVec(1, 2,  32'h22,     1, 0,  32'hBEEF,   1, 2,  32'h22,     0, 1, 0);
    addVec(0, 0,  32'h0,      0, 0,  32'h0,      0, 2,  32'h22,     0, 1, 0);
    // same-cycle pipe and long-unit to the same register
    addVec(1, 6,  32'h66,     1, 6,  32'h77,     1, 6,  32'h66,     0, 1, 0);
    addVec(0, 0,  32'h0,      0, 0,  32'h0,      0, 6,  32'h66,     0, 1, 0);
    // push and pop in the same cycle
    addVec(1, 1,  32'h1,      1, 14, 32'hE,      1, 1,  32'h1,      1, 1, 0);
    addVec(0, 0,  32'h0,      1, 15, 32'hF,      1, 14, 32'hE,      1, 1, 0);
    addVec(0, 0,  32'h0,      0, 0,  32'h0,      1, 15, 32'hF,      0, 1, 0);
    addVec(0, 0,  32'h0,      0, 0,  32'h0,      0, 15, 32'hF,      0, 1, 0);
    // dead head ahead of a live entry
    addVec(1, 1,  32'h10,     1, 20, 32'h20,     1, 1,  32'h10,     1, 1, 0);
    addVec(1, 2,  32'h30,     1, 21, 32'h21,     1, 2,  32'h30,     2, 1, 0);
    addVec(1, 20, 32'h99,     0, 0,  32'h0,      1, 20, 32'h99,     1, 1, 0);
    addVec(0, 0,  32'h0,      0, 0,  32'h0,      0, 20, 32'h99,     1, 1, 0);
    addVec(0, 0,  32'h0,      0, 0,  32'h0,      1, 21, 32'h21,     0, 1, 0);
    addVec(0, 0,  32'h0,      0, 0,  32'h0,      0, 21, 32'h21,     0, 1, 0);
    // pipe_we with address 0 is not a request; long unit bypasses
    addVec(1, 0,  32'h5,      1, 22, 32'h22,     1, 22, 32'h22,     0, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 1'b0, 5'd0, 32'h0, 3'd0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      applyStimulus(vq[i].p_we, vq[i].p_addr, vq[i].p_data,
                    vq[i].l_valid, vq[i].l_addr, vq[i].l_data);
      checkOutput($sformatf("vec%0d", i), vq[i].e_we, vq[i].e_addr, vq[i].e_data,
                  vq[i].e_pend, vq[i].e_ready, vq[i].e_stall);
    end

    // Asynchronous reset with three results buffered.
    applyStimulus(1, 1,  32'h1, 1, 23, 32'h23);
    applyStimulus(1, 2,  32'h2, 1, 24, 32'h24);
    applyStimulus(1, 3,  32'h3, 1, 25, 32'h25);
    checkOutput("fill3", 1'b1, 5'd3, 32'h3, 3'd3, 1'b1, 1'b0);
    #1;
    pipe_we = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
    lu_valid = 1'b0; lu_waddr = '0; lu_wdata = '0;
    rst = 1'b0;
    #1;
    checkOutput("async_rst", 1'b0, 5'd0, 32'h0, 3'd0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
      checkOutput($sformatf("post_rst%0d", i), 1'b0, 5'd0, 32'h0, 3'd0, 1'b1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
